// File: rtl/lsu_mem_master.sv
// Load/store initiator: one B/H/W request at a time onto a word-organised memory port.
// Define LSU_MISALIGN_SPLIT_EN to run word-crossing accesses as two memory beats.
module lsu_mem_master #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-3:0] mem_address,
   output logic [31:0]       mem_write_data,
   input  logic [31:0]       mem_read_data,
   output logic              mem_enable,
   output logic [3:0]        mem_write_flag
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

   localparam logic [ADDR_W-3:0] WORD_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       lo_q, lo_d;
   logic [31:0]       hi_q, hi_d;
   logic              err_q, err_d;
   logic              cross_q, cross_d;

   function automatic logic [2:0] size_of(input logic [1:0] f);
      case (f)
         2'b00:   size_of = 3'd1;
         2'b01:   size_of = 3'd2;
         default: size_of = 3'd4;
      endcase
   endfunction

   logic [2:0] req_size;
   logic       req_cross, req_illegal, req_bad;

   always_comb begin
      req_size    = size_of(req_funct3[1:0]);
      req_cross   = ({2'b00, req_addr[1:0]} + {1'b0, req_size}) > 4'd4;
      req_illegal = req_we ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                           : ((req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11));
`ifdef LSU_MISALIGN_SPLIT_EN
      req_bad     = req_illegal;
`else
      req_bad     = req_illegal | req_cross;
`endif
   end

   logic [1:0]        off;
   logic [2:0]        size;
   logic [7:0]        mask8;
   logic [63:0]       data64;
   logic [ADDR_W-3:0] word_addr;
   logic [31:0]       ld_word;
   logic [31:0]       ld_data;

   always_comb begin
      off       = addr_q[1:0];
      size      = size_of(f3_q[1:0]);
      mask8     = ((size == 3'd1) ? 8'h01 : (size == 3'd2) ? 8'h03 : 8'h0F) << off;
      data64    = {32'b0, wdata_q} << {off, 3'b000};
      word_addr = addr_q[ADDR_W-1:2];
      // {hi,lo} >> 8*off; a zero offset shifts hi fully out
      ld_word   = (lo_q >> {off, 3'b000}) | (hi_q << (6'd32 - {1'b0, off, 3'b000}));
      case (f3_q)
         3'b000:  ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
         3'b001:  ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
         3'b100:  ld_data = {24'b0, ld_word[7:0]};
         3'b101:  ld_data = {16'b0, ld_word[15:0]};
         default: ld_data = ld_word;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      we_d           = we_q;
      f3_d           = f3_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      lo_d           = lo_q;
      hi_d           = hi_q;
      err_d          = err_q;
      cross_d        = cross_q;
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      resp_rdata     = 32'b0;
      resp_err       = 1'b0;
      mem_address    = '0;
      mem_write_data = 32'b0;
      mem_enable     = 1'b0;
      mem_write_flag = 4'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               err_d   = req_bad;
               cross_d = req_cross;
               state_d = req_bad ? RESP : ACC0;
            end
         end
         ACC0: begin
            mem_address    = word_addr;
            mem_write_data = data64[31:0];
            mem_enable     = we_q & ~rst;
            mem_write_flag = we_q ? mask8[3:0] : 4'b0;
            if (!we_q) lo_d = mem_read_data;
            state_d = cross_q ? ACC1 : RESP;
         end
         ACC1: begin
            mem_address    = word_addr + WORD_ONE;
            mem_write_data = data64[63:32];
            mem_enable     = we_q & ~rst;
            mem_write_flag = we_q ? mask8[7:4] : 4'b0;
            if (!we_q) hi_d = mem_read_data;
            state_d = RESP;
         end
         RESP: begin
            resp_valid = ~rst;
            resp_err   = err_q;
            resp_rdata = (err_q | we_q) ? 32'b0 : ld_data;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b0;
         addr_q  <= '0;
         wdata_q <= 32'b0;
         lo_q    <= 32'b0;
         hi_q    <= 32'b0;
         err_q   <= 1'b0;
         cross_q <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         err_q   <= err_d;
         cross_q <= cross_d;
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master against a byte-writable word memory model.
module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        rst, req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err, mem_enable;
   logic [31:0] resp_rdata, mem_write_data, mem_read_data;
   logic [29:0] mem_address;
   logic [3:0]  mem_write_flag;

   always #5 clk = ~clk;

   lsu_mem_master #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data), .mem_enable(mem_enable),
      .mem_write_flag(mem_write_flag)
   );

   logic [31:0] mem [0:255];
   assign mem_read_data = mem[mem_address[7:0]];
   always @(posedge clk)
      if (mem_enable)
         for (int b = 0; b < 4; b++)
            if (mem_write_flag[b]) mem[mem_address[7:0]][8*b +: 8] <= mem_write_data[8*b +: 8];

   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   logic [31:0] r_rdata, a0_addr, a0_wd, a1_addr;
   logic [3:0]  a0_flags, a1_flags;
   logic        r_err, r_en;
   int          r_lat;

   // Issue one request, then watch up to 8 cycles for the response.
   task automatic do_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      chk("ready_idle", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      r_lat = 0; r_en = 1'b0; r_rdata = 32'b0; r_err = 1'b0;
      a0_addr = 32'b0; a0_wd = 32'b0; a0_flags = 4'b0; a1_addr = 32'b0; a1_flags = 4'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (mem_enable) r_en = 1'b1;
         if (i == 1) begin
            a0_addr = {2'b0, mem_address}; a0_flags = mem_write_flag; a0_wd = mem_write_data;
         end
         if (i == 2) begin
            a1_addr = {2'b0, mem_address}; a1_flags = mem_write_flag;
         end
         if (resp_valid) begin
            r_lat = i; r_rdata = resp_rdata; r_err = resp_err;
            break;
         end
      end
   endtask

   task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp, input int lat);
      do_req(1'b0, f3, addr, 32'b0);
      chk({tag, "_data"}, r_rdata, exp);
      chk({tag, "_err"}, {31'b0, r_err}, 32'd0);
      chk({tag, "_lat"}, r_lat, lat);
      chk({tag, "_noen"}, {31'b0, r_en}, 32'd0);
   endtask

   task automatic illegal_chk(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr);
      do_req(we, f3, addr, 32'hFFFF_FFFF);
      chk({tag, "_err"}, {31'b0, r_err}, 32'd1);
      chk({tag, "_data"}, r_rdata, 32'd0);
      chk({tag, "_lat"}, r_lat, 1);
      chk({tag, "_noen"}, {31'b0, r_en}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
      req_addr = 32'b0; req_wdata = 32'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rvalid", {31'b0, resp_valid}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", {31'b0, resp_err}, 32'd0);
      chk("rst_en", {31'b0, mem_enable}, 32'd0);
      chk("rst_flags", {28'b0, mem_write_flag}, 32'd0);
      chk("rst_addr", {2'b0, mem_address}, 32'd0);

      // word store
      do_req(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF);
      chk("sw_addr", a0_addr, 32'h40);
      chk("sw_flags", {28'b0, a0_flags}, 32'hF);
      chk("sw_en", {31'b0, r_en}, 32'd1);
      chk("sw_lat", r_lat, 2);
      chk("sw_rdata", r_rdata, 32'd0);
      chk("sw_err", {31'b0, r_err}, 32'd0);
      load_chk("lw", 3'b010, 32'h100, 32'hDEAD_BEEF, 2);

      // byte lane 3
      do_req(1'b1, 3'b000, 32'h103, 32'h0000_00A5);
      chk("sb_flags", {28'b0, a0_flags}, 32'h8);
      chk("sb_lane", {24'b0, a0_wd[31:24]}, 32'hA5);
      load_chk("lb", 3'b000, 32'h103, 32'hFFFF_FFA5, 2);
      load_chk("lbu", 3'b100, 32'h103, 32'h0000_00A5, 2);

      // upper halfword; word becomes 8001BEEF
      do_req(1'b1, 3'b001, 32'h102, 32'h0000_8001);
      chk("sh_flags", {28'b0, a0_flags}, 32'hC);
      load_chk("lh", 3'b001, 32'h102, 32'hFFFF_8001, 2);
      load_chk("lhu", 3'b101, 32'h102, 32'h0000_8001, 2);
      load_chk("lw2", 3'b010, 32'h100, 32'h8001_BEEF, 2);
      load_chk("lhu_off1", 3'b101, 32'h101, 32'h0000_01BE, 2);

      // crossing accesses
      do_req(1'b1, 3'b010, 32'h100, 32'h1122_3344);
      do_req(1'b1, 3'b010, 32'h104, 32'h5566_7788);
      do_req(1'b1, 3'b010, 32'h108, 32'h0000_0000);
`ifdef LSU_MISALIGN_SPLIT_EN
      load_chk("lw_cross", 3'b010, 32'h103, 32'h6677_8811, 3);
      do_req(1'b1, 3'b001, 32'h107, 32'h0000_BEEF);
      chk("shx_lat", r_lat, 3);
      chk("shx_a0", a0_addr, 32'h41);
      chk("shx_f0", {28'b0, a0_flags}, 32'h8);
      chk("shx_a1", a1_addr, 32'h42);
      chk("shx_f1", {28'b0, a1_flags}, 32'h1);
      load_chk("shx_w41", 3'b010, 32'h104, 32'hEF66_7788, 2);
      load_chk("shx_w42", 3'b010, 32'h108, 32'h0000_00BE, 2);
`else
      illegal_chk("lw_cross", 1'b0, 3'b010, 32'h103);
      illegal_chk("sh_cross", 1'b1, 3'b001, 32'h107);
      load_chk("shx_w41", 3'b010, 32'h104, 32'h5566_7788, 2);
      load_chk("shx_w42", 3'b010, 32'h108, 32'h0000_0000, 2);
`endif

      // illegal funct3
      illegal_chk("ill_ld011", 1'b0, 3'b011, 32'h100);
      illegal_chk("ill_ld110", 1'b0, 3'b110, 32'h100);
      illegal_chk("ill_st100", 1'b1, 3'b100, 32'h100);
      load_chk("ill_noclobber", 3'b010, 32'h100, 32'h1122_3344, 2);

      // reset while the store sits in ACC0
      do_req(1'b1, 3'b010, 32'h200, 32'hCAFE_F00D);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h200; req_wdata = 32'h1234_5678;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rsw_en_pre", {31'b0, mem_enable}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rsw_en_rst", {31'b0, mem_enable}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rsw_ready", {31'b0, req_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         chk("rsw_noresp", {31'b0, resp_valid}, 32'd0);
         @(negedge clk);
      end
      load_chk("rsw_lw", 3'b010, 32'h200, 32'hCAFE_F00D, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
